// File: rtl/calc2_pkg.sv
// Shared types and constants for the calc2 response path.
package calc2_pkg;

    localparam int NUM_PORTS    = 4;
    localparam int CALC2_DATA_W = 32;

    typedef enum logic [1:0] {
        RESP_NONE    = 2'b00,
        RESP_OK      = 2'b01,
        RESP_OVF_UNF = 2'b10,
        RESP_INVALID = 2'b11
    } resp_t;

    typedef logic [1:0] tag_t;
    typedef logic [1:0] port_t;

    typedef struct packed {
        resp_t                   resp;
        tag_t                    tag;
        logic [CALC2_DATA_W-1:0] data;
    } resp_entry_t;

endpackage

// File: rtl/calc2_resp_fifo.sv
// Per-port response FIFO: circular buffer with one extra pointer bit for full/empty.
module calc2_resp_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W+3:0] i_din,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W+3:0] o_dout
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    PTR_ONE = 1;

    logic [DATA_W+3:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              w_wr;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_dout  = r_mem[r_rptr[AW-1:0]];

    // A full FIFO still takes a push when its head leaves on the same edge.
    assign w_wr = i_push && (!o_full || i_pop);

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (w_wr)  r_wptr <= r_wptr + PTR_ONE;
            if (i_pop) r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge c_clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/calc2_resp_merger.sv
// Buffers the four calc2 response streams and merges them round-robin into one
// valid/ready stream, flagging and counting responses lost to FIFO overflow.
module calc2_resp_merger
    import calc2_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [1:0]        in_resp1,
    input  logic [1:0]        in_resp2,
    input  logic [1:0]        in_resp3,
    input  logic [1:0]        in_resp4,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    input  logic [DATA_W-1:0] in_data4,
    input  logic [1:0]        in_tag1,
    input  logic [1:0]        in_tag2,
    input  logic [1:0]        in_tag3,
    input  logic [1:0]        in_tag4,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_port,
    output logic [1:0]        out_resp,
    output logic [1:0]        out_tag,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        drop_flag,
    input  logic [3:0]        drop_clr,
    output logic [7:0]        drop_cnt
);

    localparam int ENTRY_W = DATA_W + 4;

    logic [1:0]           w_resp [NUM_PORTS];
    logic [1:0]           w_tag  [NUM_PORTS];
    logic [DATA_W-1:0]    w_data [NUM_PORTS];
    logic [ENTRY_W-1:0]   w_dout [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_push, w_pop, w_full, w_empty, w_drop;
    logic [ENTRY_W-1:0]   w_sel;
    logic                 w_load, w_grant_vld;
    port_t                w_grant, w_idx;
    logic [2:0]           w_drop_num;
    logic [8:0]           w_cnt_sum;

    logic                 r_out_valid;
    port_t                r_out_port;
    logic [1:0]           r_out_resp;
    tag_t                 r_out_tag;
    logic [DATA_W-1:0]    r_out_data;
    port_t                r_rr;
    logic [3:0]           r_drop_flag;
    logic [7:0]           r_drop_cnt;

    assign w_resp = '{in_resp1, in_resp2, in_resp3, in_resp4};
    assign w_tag  = '{in_tag1,  in_tag2,  in_tag3,  in_tag4};
    assign w_data = '{in_data1, in_data2, in_data3, in_data4};

    assign w_load = !r_out_valid || out_ready;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign w_push[g] = (resp_t'(w_resp[g]) != RESP_NONE);
        assign w_pop[g]  = w_load && w_grant_vld && (w_grant == port_t'(g));
        assign w_drop[g] = w_push[g] && w_full[g] && !w_pop[g];

        calc2_resp_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
            .c_clk   (c_clk),
            .reset   (reset),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_din   ({w_resp[g], w_tag[g], w_data[g]}),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_dout  (w_dout[g])
        );
    end

    // Scan starts one past the last granted port, so the last winner has lowest priority.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        w_grant_vld = 1'b0;
        w_grant     = r_rr;
        w_idx       = r_rr;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_idx = r_rr + port_t'(i);
            if (!w_grant_vld && !w_empty[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant     = w_idx;
            end
        end
    end

    assign w_sel = w_dout[w_grant];

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_port  <= '0;
            r_out_resp  <= '0;
            r_out_tag   <= '0;
            r_out_data  <= '0;
            r_rr        <= port_t'(NUM_PORTS - 1);
        end else if (w_load) begin
            r_out_valid <= w_grant_vld;
            if (w_grant_vld) begin
                r_out_port <= w_grant;
                r_out_resp <= w_sel[ENTRY_W-1 -: 2];
                r_out_tag  <= w_sel[DATA_W +: 2];
                r_out_data <= w_sel[DATA_W-1:0];
                r_rr       <= w_grant;
            end
        end
    end

    always_comb begin
        w_drop_num = '0;
        for (int i = 0; i < NUM_PORTS; i++) w_drop_num = w_drop_num + 3'(w_drop[i]);
    end

    assign w_cnt_sum = {1'b0, r_drop_cnt} + 9'(w_drop_num);

    // A drop in the same cycle as its clear wins, so no loss goes unreported.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_drop_flag <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_drop_flag <= (r_drop_flag & ~drop_clr) | w_drop;
            r_drop_cnt  <= w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
        end
    end

    assign out_valid = r_out_valid;
    assign out_port  = r_out_port;
    assign out_resp  = r_out_resp;
    assign out_tag   = r_out_tag;
    assign out_data  = r_out_data;
    assign drop_flag = r_drop_flag;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_calc2_resp_merger.sv
// Randomized and directed bench for calc2_resp_merger against a queue-based reference model.
module tb_calc2_resp_merger;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [1:0]        resp;
        logic [1:0]        tag;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic              c_clk = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        t_resp [4];
    logic [1:0]        t_tag  [4];
    logic [DATA_W-1:0] t_data [4];
    logic              out_ready;
    logic [3:0]        drop_clr;

    logic              out_valid;
    logic [1:0]        out_port, out_resp, out_tag;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        drop_flag;
    logic [7:0]        drop_cnt;

    // Reference model state
    ent_t       q [4][$];
    bit         m_valid;
    ent_t       m_out;
    int         m_port;
    int         m_rr;
    logic [3:0] m_flag;
    int         m_cnt;

    int n_cmp = 0;
    int n_err = 0;

    calc2_resp_merger #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .c_clk     (c_clk),
        .reset     (reset),
        .in_resp1  (t_resp[0]),
        .in_resp2  (t_resp[1]),
        .in_resp3  (t_resp[2]),
        .in_resp4  (t_resp[3]),
        .in_data1  (t_data[0]),
        .in_data2  (t_data[1]),
        .in_data3  (t_data[2]),
        .in_data4  (t_data[3]),
        .in_tag1   (t_tag[0]),
        .in_tag2   (t_tag[1]),
        .in_tag3   (t_tag[2]),
        .in_tag4   (t_tag[3]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_port  (out_port),
        .out_resp  (out_resp),
        .out_tag   (out_tag),
        .out_data  (out_data),
        .drop_flag (drop_flag),
        .drop_clr  (drop_clr),
        .drop_cnt  (drop_cnt)
    );

    always #5 c_clk = ~c_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) q[i].delete();
        m_valid = 1'b0;
        m_out   = '0;
        m_port  = 0;
        m_rr    = 3;
        m_flag  = '0;
        m_cnt   = 0;
    endtask

    // One clock edge of behaviour: output slot refills from the next non-empty
    // queue after the last winner, then arrivals join their queue if room remains.
    task automatic model_step();
        int         nd;
        logic [3:0] dm;
        bit         found;
        int         p;
        ent_t       e;
        nd    = 0;
        dm    = '0;
        found = 1'b0;
        if (!m_valid || out_ready) begin
            for (int k = 1; k <= 4; k++) begin
                p = (m_rr + k) % 4;
                if (!found && q[p].size() > 0) begin
                    found  = 1'b1;
                    m_out  = q[p].pop_front();
                    m_port = p;
                    m_rr   = p;
                end
            end
            m_valid = found;
        end
        for (int i = 0; i < 4; i++) begin
            if (t_resp[i] != 2'b00) begin
                if (q[i].size() < DEPTH) begin
                    e = {t_resp[i], t_tag[i], t_data[i]};
                    q[i].push_back(e);
                end else begin
                    dm[i] = 1'b1;
                    nd++;
                end
            end
        end
        m_flag = (m_flag & ~drop_clr) | dm;
        m_cnt  = (m_cnt + nd > 255) ? 255 : m_cnt + nd;
    endtask

    task automatic compare();
        check("out_valid", out_valid, m_valid);
        if (m_valid) begin
            check("out_port", out_port, m_port);
            check("out_resp", out_resp, m_out.resp);
            check("out_tag",  out_tag,  m_out.tag);
            check("out_data", out_data, m_out.data);
        end
        check("drop_flag", drop_flag, m_flag);
        check("drop_cnt",  drop_cnt,  m_cnt);
    endtask

    task automatic step();
        compare();
        model_step();
        @(posedge c_clk);
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < 4; i++) begin
            t_resp[i] = 2'b00;
            t_tag[i]  = 2'b00;
            t_data[i] = '0;
        end
        drop_clr = '0;
    endtask

    task automatic push(input int p, input logic [1:0] r, input logic [1:0] tg, input logic [DATA_W-1:0] d);
        t_resp[p] = r;
        t_tag[p]  = tg;
        t_data[p] = d;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        model_reset();
        @(negedge c_clk);
        reset = 1'b1;
        @(posedge c_clk);
        #1;
    endtask

    int n_seen;
    int last_port;
    bit have_last;

    initial begin
        idle();
        out_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge c_clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_port",  out_port,  2'd0);
        check("rst_data",  out_data,  '0);
        check("rst_flag",  drop_flag, 4'b0000);
        check("rst_cnt",   drop_cnt,  8'd0);
        @(negedge c_clk);
        reset = 1'b1;
        @(posedge c_clk);
        #1;

        // Single response on port 2: visible two cycles later for one cycle
        push(1, 2'b01, 2'd2, 32'h0000_00FF);
        step();
        idle();
        step();
        check("single_valid", out_valid, 1'b1);
        check("single_port",  out_port,  2'd1);
        check("single_tag",   out_tag,   2'd2);
        check("single_data",  out_data,  32'hFF);
        step();
        check("single_once", out_valid, 1'b0);
        step();

        // Simultaneous arrival on all ports from a fresh round-robin state
        do_reset();
        for (int i = 0; i < 4; i++) push(i, 2'b01, 2'd0, 32'h11 * (i + 1));
        step();
        idle();
        step();
        for (int i = 0; i < 4; i++) begin
            check("simul_port", out_port, i);
            check("simul_data", out_data, 32'h11 * (i + 1));
            step();
        end
        check("simul_end", out_valid, 1'b0);

        // Backpressure: head holds while out_ready is low, then drains back to back
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            idle();
            if (c < 3) push(0, 2'b01, 2'd1, c + 1);
            if (c >= 2) check("bp_hold", out_data, 32'd1);
            step();
        end
        idle();
        out_ready = 1'b1;
        for (int d = 1; d <= 3; d++) begin
            check("bp_seq_valid", out_valid, 1'b1);
            check("bp_seq_data",  out_data,  d);
            step();
        end
        check("bp_end", out_valid, 1'b0);

        // Overflow on port 4 with the consumer stalled
        do_reset();
        out_ready = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            push(3, 2'b10, 2'd3, 32'h100 + n);
            step();
        end
        idle();
        step();
        check("ovf_flag", drop_flag, 4'b1000);
        check("ovf_cnt",  drop_cnt,  8'd1);
        push(3, 2'b10, 2'd3, 32'h107);
        drop_clr = 4'b1000;
        step();
        idle();
        check("ovf_set_wins", drop_flag, 4'b1000);
        check("ovf_cnt2",     drop_cnt,  8'd2);
        out_ready = 1'b1;
        n_seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) n_seen++;
            step();
        end
        check("ovf_retained", n_seen, 5);
        drop_clr = 4'b1000;
        step();
        idle();
        check("ovf_clr", drop_flag, 4'b0000);

        // Fairness: two ports always busy must alternate
        do_reset();
        have_last = 1'b0;
        last_port = 0;
        for (int c = 0; c < 12; c++) begin
            push(0, 2'b01, 2'd0, 32'hA000 + c);
            push(1, 2'b01, 2'd1, 32'hB000 + c);
            if (out_valid) begin
                if (have_last) check("fair_alt", out_port, last_port ^ 1);
                last_port = out_port;
                have_last = 1'b1;
            end
            step();
        end
        idle();
        repeat (10) step();

        // Randomized traffic, ready and clears
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 2) == 0)
                    push(i, 2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), $urandom);
                else
                    push(i, 2'b00, 2'($urandom_range(0, 3)), $urandom);
            end
            out_ready = (c < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
            drop_clr  = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            step();
        end

        // Saturation: all four ports dropping every cycle
        idle();
        out_ready = 1'b0;
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < 4; i++) push(i, 2'b01, 2'(i), $urandom);
            step();
        end
        idle();
        step();
        check("sat_cnt", drop_cnt, 8'd255);

        // Asynchronous reset with entries buffered and a stalled output
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_cnt",   drop_cnt,  8'd0);
        check("arst_flag",  drop_flag, 4'b0000);
        model_reset();
        out_ready = 1'b1;
        @(negedge c_clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check("arst_no_stale", out_valid, 1'b0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/calc2_resp_merger.md
Name: calc2_resp_merger

Overview:
- Sits directly downstream of calc2_top.
- Captures the four per-port response streams (out_respN/out_dataN/out_tagN) and buffers each in its own FIFO.
- Merges them round-robin into one valid/ready stream, tagged with the originating port, for the scoreboard/checker path or the next SoC stage.
- Detects and flags responses lost to FIFO overflow.

Parameters:
- DEPTH, 4, per-port FIFO entries; power of two, >= 2
- DATA_W, 32, response data width; matches calc2 out_dataN

Ports:
- c_clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_resp1..in_resp4  in  2 each  calc2 out_respN; 00 = no response this cycle
- in_data1..in_data4  in  DATA_W each  calc2 out_dataN
- in_tag1..in_tag4  in  2 each  calc2 out_tagN
- out_valid  out  1  merged response present
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_port  out  2  originating port, 0..3 = port1..port4
- out_resp  out  2  response code
- out_tag  out  2  tag
- out_data  out  DATA_W  result data
- drop_flag  out  4  sticky per-port overflow flag
- drop_clr  in  4  per-bit clear pulse for drop_flag
- drop_cnt  out  8  total dropped responses, saturates at 255

Behaviour:
- Reset (reset = 0, asynchronous): all FIFOs empty, rr pointer = 3 (so port 0 is first priority), out_valid = 0, out_port/out_resp/out_tag/out_data = 0, drop_flag = 0, drop_cnt = 0.
- Capture: in_respN != 00 in cycle k pushes {resp, tag, data} into FIFO N at the edge ending cycle k. Ports are independent; all four may push in the same cycle.
- Full push:
  - If FIFO N is full and is also popped in the same cycle, the push is accepted.
  - Otherwise the entry is dropped, drop_flag[N] is set, and drop_cnt increments by the number of ports dropping that cycle (1..4), saturating at 255.
- drop_clr[N] clears drop_flag[N]. If a set and a clear occur in the same cycle, set wins.
- Output register: loaded when out_valid = 0 or (out_valid && out_ready).
  - Load source is the granted non-empty FIFO, popped in the same cycle.
  - If no FIFO is non-empty, out_valid goes 0.
- Stability: while out_valid && !out_ready, all out_* fields hold stable and no FIFO pops.
- Latency: a response on in_respN in cycle k with an idle, empty path gives out_valid = 1 in cycle k+2.
- Throughput: 1 response per cycle when out_ready stays 1.
- Arbitration:
  - Round-robin, scanning from rr+1 mod 4 upward; first non-empty FIFO wins.
  - rr updates to the granted port only on a pop.
  - Per-port ordering is preserved; cross-port ordering is not guaranteed.
- FIFO: circular buffer with log2(DEPTH)+1-bit read/write pointers. Full when the MSBs differ and the low bits are equal; empty when the pointers are equal. Pointers wrap naturally.
- Reset mid-operation: asynchronously discards all buffered and in-flight entries; no partial output survives.
- in_tag/in_data are ignored when in_resp = 00.

Decomposition:
- Package calc2_pkg:
  - resp_t enum: 00 NONE, 01 OK, 10 OVF_UNF, 11 INVALID.
  - tag_t (2 bits), port_t (2 bits).
  - resp_entry_t struct {resp, tag, data}.
  - NUM_PORTS = 4.
- Sub-module calc2_resp_fifo (parameterized DEPTH/DATA_W; push/pop/full/empty/dout), instantiated 4 times. Arbiter and output register stay in the top.

Test Plan:
- Single response: reset released, port 2 in_resp = 01, tag = 2, data = 0x0000_00FF for one cycle, out_ready = 1 -> two cycles later out_valid = 1 for 1 cycle with out_port = 1, resp = 01, tag = 2, data = 0xFF.
- Simultaneous: all four ports present resp = 01 in the same cycle (data 0x11, 0x22, 0x33, 0x44), out_ready = 1 -> four consecutive outputs in port order 0, 1, 2, 3, then out_valid = 0.
- Backpressure: out_ready = 0 for 10 cycles while port 0 pushes 3 responses (data 1, 2, 3) -> output holds data 1 stable; after out_ready = 1, data 1, 2, 3 follow on consecutive cycles.
- Overflow, DEPTH = 4: out_ready = 0 and port 3 pushes 6 responses -> 5 are retained (4 in FIFO + 1 in the output register), drop_flag = 4'b1000, drop_cnt = 1. A drop_clr[3] pulse coincident with a 7th push leaves drop_flag[3] = 1 and drop_cnt = 2.
- Fairness: ports 0 and 1 continuously pushing, out_ready = 1 -> out_port alternates 0, 1, 0, 1.
- Reset mid-stream: assert reset with 3 entries buffered -> out_valid = 0 immediately (asynchronous), drop_cnt = 0, and no stale outputs appear after release.
